// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared constants, FSM state type and month-length lookup for the Unix
// seconds to LED display formatter.
// ---------------------------------------------------------------------------
package clock_pkg;

  localparam int unsigned SEC_PER_DAY  = 86400;
  localparam int unsigned SEC_PER_HOUR = 3600;
  localparam int unsigned SEC_PER_MIN  = 60;
  localparam int unsigned EPOCH_YEAR   = 1970;
  // First day number that falls in 2100; the year%4 leap rule breaks there.
  localparam int unsigned MAX_DAYS     = 47482;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] ERR_CODE   = 4'hE;

  // Separator dots on led5 and led3: HH.MM.SS / YYYY.MM.DD
  localparam logic [7:0] POINT_MASK = 8'b0001_0100;

  typedef enum logic [2:0] {
    IDLE,
    DIVDAY,
    HMS,
    YEAR,
    MONTH,
    BCD,
    DONE
  } state_t;

  // Days in a month (1..12); February follows the supplied leap flag.
  function automatic logic [4:0] month_len(input logic [3:0] month, input logic leap);
    case (month)
      4'd2:                     return leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:  return 5'd30;
      default:                  return 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/seq_div64.sv
// ---------------------------------------------------------------------------
// seq_div64
// Restoring divider: 64-bit dividend by a narrow divisor, one quotient bit
// per cycle (64 cycles). done pulses for one cycle once quotient/remainder
// are final; they hold until the next start.
//   clk, reset   : clock, synchronous active-high reset
//   start        : one-cycle pulse, samples dividend
//   dividend     : 64-bit numerator
//   divisor      : DIVISOR_W-bit denominator (held constant by the user)
//   done         : one-cycle completion pulse
//   quotient     : 64-bit result
//   remainder    : DIVISOR_W-bit result (always < divisor)
// ---------------------------------------------------------------------------
module seq_div64 #(
  parameter int DIVISOR_W = 17
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [63:0]          dividend,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic                 done,
  output logic [63:0]          quotient,
  output logic [DIVISOR_W-1:0] remainder
);

  logic [63:0]          quo;
  logic [DIVISOR_W-1:0] rem;
  logic [5:0]           cnt;
  logic                 running;

  logic [DIVISOR_W:0]   shifted;
  logic [DIVISOR_W-1:0] diff;
  logic                 take;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here unconditionally); a path that skips one would infer a latch.
  always_comb begin
    shifted = {rem, quo[63]};
    take    = shifted >= {1'b0, divisor};
    // Only used when take is set, so the result is < divisor and fits.
    diff    = shifted[DIVISOR_W-1:0] - divisor;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; reset is synchronous, checked inside the
  // clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      quo     <= '0;
      rem     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quo     <= dividend;
        rem     <= '0;
        cnt     <= '0;
        running <= 1'b1;
      end else if (running) begin
        // Dividend bits shift out of quo's MSB while quotient bits enter LSB.
        quo <= {quo[62:0], take};
        rem <= take ? diff : shifted[DIVISOR_W-1:0];
        cnt <= cnt + 6'd1;
        if (cnt == 6'd63) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/unix_display_formatter.sv
// ---------------------------------------------------------------------------
// unix_display_formatter
// Converts a 64-bit Unix seconds count into packed BCD for an 8-digit LED
// scanner: HH MM SS in time mode, YYYY MM DD in date mode. Conversion is a
// multi-cycle FSM; display_bcd only updates when a conversion completes.
//   clk, reset    : clock, synchronous active-high reset
//   counter       : Unix seconds since 1970-01-01 00:00:00
//   display_year  : 1 = date mode, 0 = time mode
//   display_bcd   : {led8..led1 nibbles, point[7:0]}, led8 leftmost
//   valid         : set by the first completed conversion after reset
//   busy          : high while a conversion is in progress
// ---------------------------------------------------------------------------
module unix_display_formatter #(
  parameter int unsigned TZ_OFFSET_SEC = 0,
  parameter logic [3:0]  BLANK_CODE    = clock_pkg::BLANK_CODE,
  parameter logic [3:0]  ERR_CODE      = clock_pkg::ERR_CODE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] counter,
  input  logic        display_year,
  output logic [39:0] display_bcd,
  output logic        valid,
  output logic        busy
);

  import clock_pkg::*;

  state_t      state;
  logic [63:0] cap_sec;
  logic        cap_mode;
  logic        first_pend;

  logic        div_start;
  logic        div_done;
  logic [63:0] div_quo;
  logic [16:0] div_rem;

  logic [63:0] days;
  logic [16:0] sod;
  logic [4:0]  hour;
  logic [5:0]  min_q;
  logic [5:0]  sec_q;
  logic [11:0] year;
  logic [3:0]  month;
  logic        leap;
  logic        century;   // 1 = 20xx, 0 = 19xx
  logic        err;

  // BCD fields: 0 hour, 1 min, 2 sec, 3 month, 4 day, 5 two-digit year
  logic [6:0]  bin_val  [6];
  logic [3:0]  bin_tens [6];

  logic [63:0] sec_now;
  logic        start_cond;
  logic [63:0] year_days;
  logic [63:0] month_days;
  logic        any_ge10;

  // Offset add wraps modulo 2^64 by construction.
  assign sec_now    = counter + 64'(TZ_OFFSET_SEC);
  assign start_cond = first_pend || (sec_now != cap_sec) || (display_year != cap_mode);
  assign year_days  = (year[1:0] == 2'b00) ? 64'd366 : 64'd365;
  assign month_days = 64'(month_len(month, leap));

  always_comb begin
    any_ge10 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bin_val[i] >= 7'd10) any_ge10 = 1'b1;
    end
  end

  seq_div64 #(.DIVISOR_W(17)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (cap_sec),
    .divisor   (17'(SEC_PER_DAY)),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      display_bcd <= {{8{BLANK_CODE}}, 8'h00};
      valid       <= 1'b0;
      busy        <= 1'b0;
      cap_sec     <= '0;
      cap_mode    <= 1'b0;
      first_pend  <= 1'b1;
      div_start   <= 1'b0;
      days        <= '0;
      sod         <= '0;
      hour        <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      year        <= '0;
      month       <= '0;
      leap        <= 1'b0;
      century     <= 1'b0;
      err         <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        bin_val[i]  <= '0;
        bin_tens[i] <= '0;
      end
    end else begin
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start_cond) begin
            cap_sec    <= sec_now;
            cap_mode   <= display_year;
            first_pend <= 1'b0;
            div_start  <= 1'b1;
            busy       <= 1'b1;
            state      <= DIVDAY;
          end
        end

        DIVDAY: begin
          if (div_done) begin
            days  <= div_quo;
            sod   <= div_rem;
            hour  <= '0;
            min_q <= '0;
            state <= (div_quo >= 64'(MAX_DAYS)) ? DONE : HMS;
            err   <= (div_quo >= 64'(MAX_DAYS));
          end
        end

        // Hours drain first; once sod < 3600 only the minute branch can fire.
        HMS: begin
          if (sod >= 17'(SEC_PER_HOUR)) begin
            sod  <= sod - 17'(SEC_PER_HOUR);
            hour <= hour + 5'd1;
          end else if (sod >= 17'(SEC_PER_MIN)) begin
            sod   <= sod - 17'(SEC_PER_MIN);
            min_q <= min_q + 6'd1;
          end else begin
            sec_q <= sod[5:0];
            year  <= 12'(EPOCH_YEAR);
            state <= YEAR;
          end
        end

        YEAR: begin
          if (days >= year_days) begin
            days <= days - year_days;
            year <= year + 12'd1;
          end else begin
            leap  <= (year[1:0] == 2'b00);
            month <= 4'd1;
            state <= MONTH;
          end
        end

        // Leftover days (< month length) become the 1-based day of month.
        MONTH: begin
          if (days >= month_days) begin
            days  <= days - month_days;
            month <= month + 4'd1;
          end else begin
            century    <= (year >= 12'd2000);
            bin_val[0] <= 7'(hour);
            bin_val[1] <= 7'(min_q);
            bin_val[2] <= 7'(sec_q);
            bin_val[3] <= 7'(month);
            bin_val[4] <= 7'(days[4:0]) + 7'd1;
            bin_val[5] <= (year >= 12'd2000) ? 7'(year - 12'd2000) : 7'(year - 12'd1900);
            for (int i = 0; i < 6; i++) bin_tens[i] <= '0;
            state <= BCD;
          end
        end

        // All fields strip a ten in parallel; at most 9 passes for 0..99.
        BCD: begin
          if (any_ge10) begin
            for (int i = 0; i < 6; i++) begin
              if (bin_val[i] >= 7'd10) begin
                bin_val[i]  <= bin_val[i] - 7'd10;
                bin_tens[i] <= bin_tens[i] + 4'd1;
              end
            end
          end else begin
            state <= DONE;
          end
        end

        DONE: begin
          if (err) begin
            display_bcd <= {{8{ERR_CODE}}, 8'h00};
          end else if (cap_mode) begin
            display_bcd <= {century ? 4'd2 : 4'd1, century ? 4'd0 : 4'd9,
                            bin_tens[5], 4'(bin_val[5]),
                            bin_tens[3], 4'(bin_val[3]),
                            bin_tens[4], 4'(bin_val[4]),
                            POINT_MASK};
          end else begin
            display_bcd <= {BLANK_CODE, BLANK_CODE,
                            bin_tens[0], 4'(bin_val[0]),
                            bin_tens[1], 4'(bin_val[1]),
                            bin_tens[2], 4'(bin_val[2]),
                            POINT_MASK};
          end
          valid <= 1'b1;
          busy  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
